buffer_mem_responder: RTL
=========================

Name: buffer_mem_responder

Overview:
Responder end of the single-port buffer-memory interface that the matrix-multiply engine drives. The engine drives active-low chip enable, active-low write enable, an address and lane-packed data.
- One instance models each of the ob/ib/wb/ps buffers for simulation and FPGA bring-up.
- Provides a secondary host port so the bench or SoC can preload operands and dump results.
- Keeps access statistics and sticky error flags.

Parameters:
WIDTH, 8, bits per lane
LANES, 4, lanes per word (ROW or COL of the array)
DEPTH, 256, number of words
STARVE, 16, consecutive host stall cycles before starve flag sets

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
mem_cenb_i  in  1  core chip enable, active low
mem_wenb_i  in  1  core write enable, active low
mem_addr_i  in  $clog2(DEPTH)  core address
mem_data_i  in  LANES*WIDTH  core write data ([LANES-1:0][WIDTH-1:0])
mem_data_o  out  LANES*WIDTH  core read data
host_req_i  in  1  host access request, held until granted
host_we_i  in  1  host write (1) / read (0)
host_addr_i  in  $clog2(DEPTH)  host address
host_wdata_i  in  LANES*WIDTH  host write data
host_gnt_o  out  1  host access accepted this cycle
host_rvalid_o  out  1  host read data valid
host_rdata_o  out  LANES*WIDTH  host read data
clr_stats_i  in  1  synchronous clear of counters and flags
rd_cnt_o  out  16  core read count, saturating
wr_cnt_o  out  16  core write count, saturating
addr_err_o  out  1  sticky: access to address >= DEPTH
starve_o  out  1  sticky: host stalled STARVE consecutive cycles

Behaviour:
- Reset (async, rst_i=1): mem_data_o, host_rdata_o, host_rvalid_o, counters, stall counter, addr_err_o and starve_o all go to 0. Array contents are not reset. An in-flight read is discarded: no rvalid after reset releases.
- Core port has absolute priority. Its accesses are sampled at posedge when mem_cenb_i=0.
  - Write (wenb=0): word written at that edge.
  - Read (wenb=1): mem_data_o updated at that edge, i.e. 1-cycle latency.
  - mem_data_o holds its last read value when the core is idle or writing (SRAM output-latch behaviour).
- Host port: host_gnt_o = host_req_i & mem_cenb_i & ~rst_i, combinational.
  - The access executes at the edge ending the grant cycle.
  - Host read: host_rdata_o loads and host_rvalid_o=1 for exactly the next cycle.
  - Host must hold req/we/addr/wdata stable until the gnt cycle. req high again after gnt is a new request, so back-to-back one access per cycle is allowed.
  - host_rdata_o holds its value after rvalid drops.
- Simultaneous core and host access: the host stalls (gnt=0). There is no conflict error, even at the same address.
- Starvation: a counter increments each cycle with host_req_i & ~host_gnt_o and clears on gnt or when req=0. Reaching STARVE sets starve_o (sticky).
- Out-of-range address (only possible when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns 0 and still produces rvalid for the host.
  - addr_err_o sets. Applies to both ports.
- Counters: rd_cnt_o / wr_cnt_o count core accesses only, including out-of-range ones, and saturate at 16'hFFFF.
- clr_stats_i clears counters and both sticky flags at the edge. An access in the same cycle is not counted, and an error in the same cycle is not flagged (clear wins). It does not affect array contents or the data outputs.
- Same-cycle core write and core read is impossible (single port). A host read in the cycle after a core write to the same address returns the new data.

Decomposition:
- Shared package (existing team package alongside the array/controller typedefs):
  - mem_word_t as logic [LANES-1:0][WIDTH-1:0].
  - A host request struct {req, we, addr, wdata}.
  - Localparam ADDR_W = $clog2(DEPTH).
- Sub-module: sat_counter (WIDTH_C param, inc, clr, saturating). It is instanced for rd_cnt, wr_cnt and the starvation counter (starve variant compares against STARVE).

Test Plan:
- Reset then core write addr 5 = 32'h04030201, read addr 5 next cycle -> mem_data_o=32'h04030201 one cycle after the read edge; wr_cnt_o=1, rd_cnt_o=1.
- Host write addr 10 = 32'hDEADBEEF while core idle -> gnt same cycle. Host read addr 10 -> rvalid pulses 1 cycle with rdata=32'hDEADBEEF.
- Core reads addr 0..19 continuously while host_req_i held -> gnt=0 throughout, starve_o=1 after 16 stalled cycles; gnt on the first idle core cycle; starve_o stays 1 until clr_stats_i.
- DEPTH=200 build: core write addr 210 then read addr 210 -> mem_data_o=0, addr_err_o=1, array word 210 mod anything unchanged (re-read addr 10 intact).
- 70000 core reads -> rd_cnt_o saturates at 16'hFFFF. clr_stats_i together with a read -> rd_cnt_o=0.
- Host read granted, rst_i asserted during the following cycle -> host_rvalid_o=0 and host_rdata_o=0 immediately; no rvalid after release.

Source files
------------

// File: rtl/buffer_mem_responder_pkg.sv
// Shared types for the buffer-memory responder: default geometry, the word and
// host-request types, and the access decode used by the responder datapath.
package buffer_mem_responder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_STARVE = 16;
    localparam int ADDR_W     = $clog2(DEF_DEPTH);

    typedef logic [DEF_LANES-1:0][DEF_WIDTH-1:0] mem_word_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        mem_word_t         wdata;
    } host_req_t;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_CORE_RD,
        ACC_CORE_WR,
        ACC_HOST_RD,
        ACC_HOST_WR
    } acc_kind_t;

    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/buffer_mem_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH_C = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [WIDTH_C-1:0] cnt_o
);

    logic [WIDTH_C-1:0] cnt_q;
    logic [WIDTH_C-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/buffer_mem_responder.sv
// Single-port buffer memory responder: core port with absolute priority, a
// stall-able host port, saturating access counters and sticky error flags.
module buffer_mem_responder
    import buffer_mem_responder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int STARVE = DEF_STARVE
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               mem_cenb_i,
    input  logic                               mem_wenb_i,
    input  logic [$clog2(DEPTH)-1:0]           mem_addr_i,
    input  logic [LANES-1:0][WIDTH-1:0]        mem_data_i,
    output logic [LANES-1:0][WIDTH-1:0]        mem_data_o,
    input  logic                               host_req_i,
    input  logic                               host_we_i,
    input  logic [$clog2(DEPTH)-1:0]           host_addr_i,
    input  logic [LANES-1:0][WIDTH-1:0]        host_wdata_i,
    output logic                               host_gnt_o,
    output logic                               host_rvalid_o,
    output logic [LANES-1:0][WIDTH-1:0]        host_rdata_o,
    input  logic                               clr_stats_i,
    output logic [15:0]                        rd_cnt_o,
    output logic [15:0]                        wr_cnt_o,
    output logic                               addr_err_o,
    output logic                               starve_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE + 1);

    typedef logic [LANES-1:0][WIDTH-1:0] word_t;

    word_t         mem [DEPTH];

    acc_kind_t     acc;
    logic [AW-1:0] accAddr;
    logic          addrOk;
    logic          hostGnt;
    logic          stall;
    logic          wrEn;
    word_t         wrData;
    word_t         rdWord;
    logic [SW-1:0] stallCnt;

    word_t         memData_q,   memData_d;
    word_t         hostRdata_q, hostRdata_d;
    logic          hostRvalid_q, hostRvalid_d;
    logic          addrErr_q,   addrErr_d;
    logic          starve_q,    starve_d;

    // The core owns the single port whenever it is enabled; the host only gets
    // the cycle when the core is idle, so at most one access happens per edge.
    always_comb begin
        hostGnt = host_req_i & mem_cenb_i & ~rst_i;
        stall   = host_req_i & ~hostGnt;
        acc     = ACC_IDLE;
        accAddr = host_addr_i;
        if (!mem_cenb_i) begin
            acc     = mem_wenb_i ? ACC_CORE_RD : ACC_CORE_WR;
            accAddr = mem_addr_i;
        end else if (hostGnt) begin
            acc = host_we_i ? ACC_HOST_WR : ACC_HOST_RD;
        end
        addrOk = addr_ok(32'(accAddr), DEPTH);
        rdWord = addrOk ? mem[accAddr] : '0;
        wrEn   = addrOk & ((acc == ACC_CORE_WR) | (acc == ACC_HOST_WR));
        wrData = (acc == ACC_CORE_WR) ? mem_data_i : host_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem[accAddr] <= wrData;
        end
    end

    always_comb begin
        memData_d    = memData_q;
        if (acc == ACC_CORE_RD) begin
            memData_d = rdWord;
        end
        hostRvalid_d = (acc == ACC_HOST_RD);
        hostRdata_d  = hostRvalid_d ? rdWord : hostRdata_q;
        if (clr_stats_i) begin
            addrErr_d = 1'b0;
            starve_d  = 1'b0;
        end else begin
            addrErr_d = addrErr_q | ((acc != ACC_IDLE) & ~addrOk);
            starve_d  = starve_q | (stall & (stallCnt >= SW'(STARVE - 1)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            memData_q    <= '0;
            hostRdata_q  <= '0;
            hostRvalid_q <= 1'b0;
            addrErr_q    <= 1'b0;
            starve_q     <= 1'b0;
        end else begin
            memData_q    <= memData_d;
            hostRdata_q  <= hostRdata_d;
            hostRvalid_q <= hostRvalid_d;
            addrErr_q    <= addrErr_d;
            starve_q     <= starve_d;
        end
    end

    sat_counter #(.WIDTH_C(16)) uRdCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (acc == ACC_CORE_RD),
        .clr_i (clr_stats_i),
        .cnt_o (rd_cnt_o)
    );

    sat_counter #(.WIDTH_C(16)) uWrCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (acc == ACC_CORE_WR),
        .clr_i (clr_stats_i),
        .cnt_o (wr_cnt_o)
    );

    // Stall run length: restarts whenever the host is granted or stops asking.
    sat_counter #(.WIDTH_C(SW)) uStallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall),
        .clr_i (~stall | clr_stats_i),
        .cnt_o (stallCnt)
    );

    assign host_gnt_o    = hostGnt;
    assign mem_data_o    = memData_q;
    assign host_rdata_o  = hostRdata_q;
    assign host_rvalid_o = hostRvalid_q;
    assign addr_err_o    = addrErr_q;
    assign starve_o      = starve_q;

endmodule
